cla_seq_addsub: RTL and testbench
=================================

# cla_seq_addsub

Sequential multi-precision adder/subtractor controller that time-multiplexes one 4-bit carry-lookahead slice across a WIDTH-bit operand pair. It processes one 4-bit slice per clock, least-significant slice first, and carries between slices in a register. It provides a start/ready/done handshake for multi-cycle arithmetic units that cannot afford a full-width CLA tree. Internally, each slice sum is formed with the group generate/propagate formulation (g, p, c_in -> c_out) used by the team's CLA slices.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 slices.

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request; accepted only when ready=1
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  1 = idle, start will be accepted
- done  output  1  one-cycle pulse, result valid
- s  output  WIDTH  sum/difference
- c_out  output  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow

## Operation
- Clocking: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- FSM states: IDLE, RUN, DONE.
- IDLE (ready=1):
  - start=1 latches a into opA and (sub ? ~b : b) into opB.
  - Sets carry register = sub, slice index idx = 0, clears s, c_out and ovf, then goes to RUN.
- RUN (ready=0), each cycle:
  - slice = opA[4*idx+3:4*idx] + opB[...] + carry, written to s[4*idx+3:4*idx].
  - carry <= slice carry-out; idx <= idx+1.
  - On the slice idx = N-1:
    - c_out <= carry-out;
    - ovf <= carry into bit WIDTH-1 XOR carry-out;
    - go to DONE.
- DONE: done=1, ready=0 for exactly one cycle, then IDLE.
- Results:
  - s, c_out and ovf hold their values in IDLE until the next accepted start.
  - s is not valid during RUN (partial slices visible).
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - idx counter width is clog2(N), minimum 1.
  - For N=1, RUN lasts one cycle.
- Boundary conditions:
  - start while ready=0: ignored, no queuing.
  - start held high continuously: a new operation is accepted in each IDLE cycle, giving a throughput of one result per N+2 cycles.
  - sub=1 with b=0: result a, c_out=1, ovf=0.
  - Changes to a, b or sub after acceptance have no effect.
- Reset (rst_n=0 at a rising edge, in any state including mid-RUN): next cycle is IDLE with:
  - ready=1, done=0, s=0, c_out=0, ovf=0;
  - internal carry, idx, opA and opB cleared;
  - no done pulse for the aborted operation.

## Timing
- Reset values: ready=1, done=0, s=0, c_out=0, ovf=0.
- Let edge E0 be the edge that accepts start. Then:
  - RUN occupies cycles after E0 .. E(N-1), one slice per edge E1..EN.
  - done is high in the cycle after EN.
  - ready returns high one cycle after done.
- Latency is N+1 edges from acceptance to done (WIDTH=16: 5).
- All outputs are registered; no combinational path from inputs to outputs.
- ready and done are never high simultaneously.

## Test plan
- Reset then WIDTH=16 add: a=0x1234, b=0x0FCD, sub=0.
  - done exactly 5 edges after acceptance.
  - s=0x2201, c_out=0, ovf=0.
  - ready=0 for 5 cycles, then 1.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, sub=0.
  - s=0x0000, c_out=1, ovf=0.
  - Then a=0x7FFF, b=0x0001: s=0x8000, c_out=0, ovf=1.
- Subtraction: a=0x8000, b=0x0001, sub=1 gives s=0x7FFF, c_out=1, ovf=1.
  - Then a=0x0003, b=0x0005, sub=1 gives s=0xFFFE, c_out=0, ovf=0.
- Busy rejection: pulse start with a=0x1111, b=0x1111 mid-RUN of the 0x1234+0x0FCD operation.
  - Original result 0x2201 is returned.
  - Only one done pulse occurs; no second operation starts.
- Reset mid-operation: assert rst_n=0 for one edge during the 2nd RUN cycle.
  - Next cycle: ready=1, done=0, s=0.
  - No done pulse follows.
  - A subsequent 0x0001+0x0002 yields s=0x0003.
- Back-to-back with start held high, three operands streamed.
  - done pulses spaced exactly 6 cycles apart.
  - Each result held until the next acceptance.
  - Random add/sub regression vs. reference model for WIDTH=4, 16, 32.

Source files
------------

// File: rtl/cla_seq_addsub_if.sv
// Start/ready/done handshake and operand/result bus for the sequential CLA add/sub unit.
interface cla_seq_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  ready, done, s, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, s, c_out, ovf
    );
endinterface

// File: rtl/cla_seq_addsub.sv
// Multi-precision adder/subtractor: one 4-bit carry-lookahead slice reused per clock,
// LSB slice first, with the inter-slice carry held in a register.
module cla_seq_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_seq_addsub_if.slave  bus
);
    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  s_q;
    logic              c_out_q;
    logic              ovf_q;
    logic              ready_q;
    logic              done_q;

    logic [3:0]        sl_a;
    logic [3:0]        sl_b;
    logic [3:0]        sl_g;
    logic [3:0]        sl_p;
    logic [4:0]        sl_c;
    logic [3:0]        sl_sum;
    logic [WIDTH-1:0]  s_d;
    logic              last_c;

    // Current slice: operand select, group generate/propagate lookahead, result merge.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                sl_a = op_a_q[i*4 +: 4];
                sl_b = op_b_q[i*4 +: 4];
            end
        end
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
        sl_sum  = sl_p ^ sl_c[3:0];
        s_d     = s_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                s_d[i*4 +: 4] = sl_sum;
            end
        end
        last_c = (idx_q == IDXW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        s_q     <= '0;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= sl_c[4];
                    idx_q   <= idx_q + IDXW'(1);
                    // Overflow: carry into the sign bit differs from carry out of it.
                    if (last_c) begin
                        c_out_q <= sl_c[4];
                        ovf_q   <= sl_c[3] ^ sl_c[4];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_cla_seq_addsub.sv
// Scoreboard bench for cla_seq_addsub (WIDTH=16): directed vectors, busy rejection,
// mid-operation reset and back-to-back streaming.
module tb_cla_seq_addsub;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_seq_addsub_if #(.WIDTH(WIDTH)) bus_if();
    cla_seq_addsub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        string            name;
    } exp_t;

    exp_t sb_q[$];
    int   done_cyc_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the oldest expectation whenever the DUT presents done.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus_if.done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            check("ready_low_during_done", 32'(bus_if.ready), 32'd0);
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 s=0x%0h expected no pending result", bus_if.s);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_s"},     32'(bus_if.s),     32'(e.s));
                check({e.name, "_c_out"}, 32'(bus_if.c_out), 32'(e.c));
                check({e.name, "_ovf"},   32'(bus_if.ovf),   32'(e.v));
            end
        end
    end

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (bus_if.ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check({name, "_ready_timeout"}, 32'(bus_if.ready), 32'd1);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic ev,
                         input string name, input bit push);
        exp_t e;
        wait_ready(name);
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.sub   = sub;
        bus_if.start = 1'b1;
        if (push) begin
            e = '{s: es, c: ec, v: ev, name: name};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a     = ~a;
        bus_if.b     = ~b;
        bus_if.sub   = ~sub;
    endtask

    // Follows an accepted op until ready returns; optionally pokes start while busy.
    task automatic finish_op(input bit poke, output int low, output int dcyc, output int ndone);
        bit seen_ready;
        low = 0; dcyc = 0; ndone = 0; seen_ready = 1'b0;
        for (int k = 1; k <= 30 && !seen_ready; k++) begin
            @(negedge clk);
            if (poke && k == 2) begin
                bus_if.a     = 16'h1111;
                bus_if.b     = 16'h1111;
                bus_if.sub   = 1'b0;
                bus_if.start = 1'b1;
            end else if (poke && k == 3) begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done === 1'b1) begin
                ndone++;
                if (dcyc == 0) dcyc = k;
            end
            if (bus_if.ready === 1'b1) seen_ready = 1'b1;
            else low++;
        end
        if (!seen_ready) check("finish_timeout", 32'(bus_if.ready), 32'd1);
    endtask

    task automatic run_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                           input logic [WIDTH-1:0] es, input logic ec, input logic ev,
                           input string name);
        int low, dc, nd;
        issue(a, b, sub, es, ec, ev, name, 1'b1);
        finish_op(1'b0, low, dc, nd);
        check({name, "_done_count"}, 32'(nd), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int low, dc, nd, cnt, k;
        logic [WIDTH-1:0] b2b_a [3];
        logic [WIDTH-1:0] b2b_b [3];
        logic             b2b_sub [3];
        logic [WIDTH-1:0] b2b_s [3];
        logic             b2b_c [3];
        logic             b2b_v [3];
        exp_t             e;

        bus_if.start = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus_if.ready), 32'd1);
        check("rst_done",  32'(bus_if.done),  32'd0);
        check("rst_s",     32'(bus_if.s),     32'd0);
        check("rst_c_out", 32'(bus_if.c_out), 32'd0);
        check("rst_ovf",   32'(bus_if.ovf),   32'd0);
        rst_n = 1'b1;

        // First add, with a start pulse while busy that must be ignored.
        issue(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "add1", 1'b1);
        finish_op(1'b1, low, dc, nd);
        check("add1_ready_low_cycles", 32'(low), 32'd5);
        check("add1_done_cycle",       32'(dc),  32'd5);
        check("add1_done_count",       32'(nd),  32'd1);
        repeat (2) @(negedge clk);
        check("add1_hold_s",     32'(bus_if.s),     32'h2201);
        check("add1_idle_ready", 32'(bus_if.ready), 32'd1);

        run_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        run_vec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        run_vec(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_vec(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_vec(16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0, "sub_zero");
        run_vec(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
        run_vec(16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0, "sub_m1");

        // Reset during the second RUN cycle aborts the op with no done pulse.
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, "aborted", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", 32'(bus_if.ready), 32'd1);
        check("abort_done",  32'(bus_if.done),  32'd0);
        check("abort_s",     32'(bus_if.s),     32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_vec(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "post_abort");

        // Back-to-back with start held high.
        b2b_a   = '{16'h0100, 16'hA000, 16'h5000};
        b2b_b   = '{16'h0200, 16'hA000, 16'h6000};
        b2b_sub = '{1'b0, 1'b0, 1'b1};
        b2b_s   = '{16'h0300, 16'h4000, 16'hF000};
        b2b_c   = '{1'b0, 1'b1, 1'b0};
        b2b_v   = '{1'b0, 1'b1, 1'b0};
        done_cyc_q.delete();
        for (int j = 0; j < 3; j++) begin
            wait_ready("b2b");
            if (j > 0) check("b2b_hold_s", 32'(bus_if.s), 32'(b2b_s[j-1]));
            bus_if.a     = b2b_a[j];
            bus_if.b     = b2b_b[j];
            bus_if.sub   = b2b_sub[j];
            bus_if.start = 1'b1;
            e = '{s: b2b_s[j], c: b2b_c[j], v: b2b_v[j], name: "b2b"};
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus_if.start = 1'b0;
        k = 0;
        while (done_cyc_q.size() < 3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_pulses", 32'(done_cyc_q.size()), 32'd3);
        if (done_cyc_q.size() >= 3) begin
            check("b2b_spacing_1", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd6);
            check("b2b_spacing_2", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd6);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
